lift_call_scheduler: RTL and testbench
======================================

Name: lift_call_scheduler

Overview:
- Upstream controller for the floor counter.
- Latches hall/car call buttons and compares them with the current floor fed back from the counter output.
- Drives the counter's step-enable (sel) and direction (mode) one floor at a time, and holds a door-open window at each served floor.
- Uses a collective (SCAN) policy: keeps travelling in one direction while calls exist ahead, otherwise reverses.

Parameters:
- N, 8, width of the floor number (matches the floor counter width).
- FLOORS, 8, number of served floors; width of the call vector; valid floors 0..FLOORS-1.
- TRAVEL_CYCLES, 2, cycles spent in SETTLE after each step pulse (min 1).
- DOOR_CYCLES, 4, cycles door_open is held at a served floor (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  FLOORS  call buttons; req[i]=1 in any cycle registers a call for floor i.
- floor  in  N  current floor, taken from the floor counter output q.
- sel  out  1  step enable to floor counter; 1-cycle pulse per floor step.
- mode  out  1  direction to floor counter: 1 = up, 0 = down.
- door_open  out  1  door open indication.
- pending  out  FLOORS  latched, unserved calls.
- busy  out  1  (state != IDLE) or (|pending).

Behaviour:
- Reset (rst=0, async): state=IDLE, pending=0, dir=1 (up), timer=0. Outputs go to sel=0, mode=1, door_open=0, busy=0.
- Moore outputs decoded from registered state only:
  - sel=1 only in STEP.
  - door_open=1 only in DOOR.
  - mode=dir at all times.
- Call latching: at each edge, pending[i] <= pending[i] | req[i], except in these cases:
  - on entry to DOOR at floor f, pending[f] clears;
  - while in DOOR, req[f] is ignored for the current floor f.
  - Other floors keep latching in every state.
- Helper terms, evaluated against the live floor input:
  - above = any pending[i] with i > floor.
  - below = any pending[i] with i < floor.
  - here = (floor < FLOORS) and pending[floor].
- Decision function D:
  - If here: go to DOOR.
  - Else if dir=1 and above: go to STEP.
  - Else if dir=0 and below: go to STEP.
  - Else if above or below: invert dir, then go to STEP.
  - Else: go to IDLE.
  - dir updates only on a transition into STEP, so mode is stable during every sel pulse.
- States:
  - IDLE: apply D every cycle; stay in IDLE while nothing is pending.
  - STEP: exactly one cycle, sel=1. Next state SETTLE with timer=TRAVEL_CYCLES-1. The counter updates floor at the same edge.
  - SETTLE: sel=0. Decrement timer. When timer==0, apply D using the new floor.
  - DOOR: door_open=1. timer loads DOOR_CYCLES-1 on entry and decrements. When timer==0, apply D; here is false by construction, so DOOR never chains into DOOR.
- Latency: a call for a floor other than the current one, registered at edge k, gives IDLE→STEP at edge k+1, so sel is high in cycle k+1.
- Boundaries:
  - The scheduler never pulses sel with dir=1 at floor FLOORS-1, or with dir=0 at floor 0, because no call exists beyond either end.
  - An out-of-range floor (floor >= FLOORS) makes here=0 and below = |pending, so the car moves down.
  - A call arriving during SETTLE for the floor just reached is served at that same decision.
  - A call arriving behind the car is served after the calls ahead are exhausted.
- Reset asserted mid-operation: immediate return to reset values; pending calls are lost.

Test Plan:
1. Reset, floor=0, pulse req[3] for one cycle → three sel pulses with mode=1, each followed by 2 SETTLE cycles; then door_open=1 for 4 cycles at floor 3; pending=0; busy=0 afterwards.
2. Idle at floor 2, pulse req[2] → DOOR entered next edge, sel never asserted, door_open 4 cycles, pending[2] cleared; req[2] held during DOOR does not re-latch.
3. At floor 4 moving up toward call 6, pulse req[1] while in SETTLE → car continues to 6 (door), then dir flips to 0, five down steps to 1, door opens.
4. Calls {1,5} pending while idle at 3 with dir=1 → serves 5 first, then 1; mode never changes during any cycle where sel=1.
5. Drop rst mid-SETTLE with pending=8'h81 → outputs and pending go to 0 asynchronously (before the next clock edge); after release, IDLE with busy=0.
6. Floor counter at top, floor=7 (FLOORS=8), no call above → no sel pulse with mode=1 is ever issued; req[0] → seven down steps.

Source files
------------

// File: rtl/lift_call_if.sv
// Call-scheduler bundle: call buttons and floor feedback in; step/direction, door and status out.
// master = the scheduler side, slave = the counter/panel side.
interface lift_call_if #(
  parameter int N      = 8,
  parameter int FLOORS = 8
);
  logic [FLOORS-1:0] req;
  logic [N-1:0]      floor;
  logic              sel;
  logic              mode;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  logic              busy;

  modport master (
    input  req, floor,
    output sel, mode, door_open, pending, busy
  );

  modport slave (
    output req, floor,
    input  sel, mode, door_open, pending, busy
  );
endinterface

// File: rtl/lift_call_scheduler.sv
// Collective (SCAN) lift call scheduler: latches calls and drives the floor counter one step at a time.
// Each step is followed by a settle window; each served floor gets a door-open window.
module lift_call_scheduler #(
  parameter int N             = 8,
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic         clk,
  input  logic         rst,
  lift_call_if.master  bus
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] TRAVEL_T = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_T   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, DOOR} state_t;

  state_t            state, state_nxt, d_state;
  logic              dir, dir_nxt, d_dir;
  logic [TW-1:0]     timer, timer_nxt;
  logic [FLOORS-1:0] pending, pending_nxt, door_mask;
  logic              above, below, here;

  // Positions of latched calls relative to the live floor; an out-of-range floor sees every call as below.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i]) begin
        if (i > int'(bus.floor)) above = 1'b1;
        if (i < int'(bus.floor)) below = 1'b1;
        if (i == int'(bus.floor)) here = 1'b1;
      end
    end
  end

  always_comb begin
    d_state = IDLE;
    d_dir   = dir;
    if (here) begin
      d_state = DOOR;
    end else if ((dir && above) || (!dir && below)) begin
      d_state = STEP;
    end else if (above || below) begin
      d_state = STEP;
      d_dir   = ~dir;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dir     <= 1'b1;
      timer   <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      dir     <= dir_nxt;
      timer   <= timer_nxt;
      pending <= pending_nxt;
    end
  end

  // dir only moves together with a transition into STEP, since d_dir differs from dir only then.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        state_nxt = d_state;
        dir_nxt   = d_dir;
      end
      STEP: begin
        state_nxt = SETTLE;
        timer_nxt = TRAVEL_T;
      end
      SETTLE, DOOR: begin
        if (timer == '0) begin
          state_nxt = d_state;
          dir_nxt   = d_dir;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == DOOR && state != DOOR) timer_nxt = DOOR_T;
  end

  // The served floor's call clears on door entry and its button is ignored until the door window ends.
  always_comb begin
    door_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      door_mask[i] = (i == int'(bus.floor)) && (state == DOOR || state_nxt == DOOR);
    end
    pending_nxt = (pending | bus.req) & ~door_mask;
  end

  always_comb begin
    bus.sel       = (state == STEP);
    bus.door_open = (state == DOOR);
    bus.mode      = dir;
    bus.pending   = pending;
    bus.busy      = (state != IDLE) || (|pending);
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler; the floor counter is modelled inline, stepping after each sel pulse.
module tb_lift_call_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   ups, downs, n, dl;

  lift_call_if #(.N(8), .FLOORS(8)) ifc ();

  lift_call_scheduler #(
    .N(8), .FLOORS(8), .TRAVEL_CYCLES(2), .DOOR_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the counter model follows the sel/mode values present before the edge.
  task automatic tick();
    logic s, m;
    s = ifc.sel;
    m = ifc.mode;
    @(posedge clk);
    #1;
    if (s) ifc.floor = m ? ifc.floor + 8'd1 : ifc.floor - 8'd1;
  endtask

  task automatic travel(input int budget, output int u, output int d, output int cyc);
    u = 0; d = 0; cyc = 0;
    while (!ifc.door_open && cyc < budget) begin
      if (ifc.sel) begin
        if (ifc.mode) u++;
        else d++;
      end
      tick();
      cyc++;
    end
    chk("reach_door", ifc.door_open, 1);
  endtask

  task automatic door_len(output int cyc);
    cyc = 0;
    while (ifc.door_open && cyc < 20) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    rst       = 1'b0;
    ifc.req   = '0;
    ifc.floor = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", ifc.sel, 0);
    chk("rst_mode", ifc.mode, 1);
    chk("rst_door", ifc.door_open, 0);
    chk("rst_pending", ifc.pending, 0);
    chk("rst_busy", ifc.busy, 0);
    rst = 1'b1;

    // 1: single call for floor 3 from floor 0
    ifc.req = 8'h08; tick(); ifc.req = '0;
    chk("t1_latched", ifc.pending, 8'h08);
    chk("t1_busy", ifc.busy, 1);
    chk("t1_sel_idle", ifc.sel, 0);
    tick();
    chk("t1_latency_sel", ifc.sel, 1);
    chk("t1_latency_mode", ifc.mode, 1);
    travel(60, ups, downs, n);
    chk("t1_ups", ups, 3);
    chk("t1_downs", downs, 0);
    chk("t1_cycles", n, 9);
    chk("t1_floor", ifc.floor, 3);
    door_len(dl);
    chk("t1_door_len", dl, 4);
    chk("t1_pending", ifc.pending, 0);
    chk("t1_busy_end", ifc.busy, 0);

    // 2: call at the current floor, button held through the door window
    ifc.floor = 8'd2;
    ifc.req = 8'h04; tick();
    chk("t2_latched", ifc.pending, 8'h04);
    tick();
    chk("t2_door", ifc.door_open, 1);
    chk("t2_cleared", ifc.pending, 0);
    chk("t2_sel", ifc.sel, 0);
    door_len(dl);
    chk("t2_door_len", dl, 4);
    chk("t2_no_relatch", ifc.pending, 0);
    ifc.req = '0; tick();
    chk("t2_pending_end", ifc.pending, 0);
    chk("t2_busy_end", ifc.busy, 0);
    chk("t2_floor", ifc.floor, 2);

    // 3: call behind the car registered during SETTLE
    ifc.floor = 8'd4;
    ifc.req = 8'h40; tick(); ifc.req = '0;
    tick();
    chk("t3_step_sel", ifc.sel, 1);
    chk("t3_step_mode", ifc.mode, 1);
    tick();
    chk("t3_settle_sel", ifc.sel, 0);
    ifc.req = 8'h02; tick(); ifc.req = '0;
    chk("t3_latched", ifc.pending, 8'h42);
    travel(60, ups, downs, n);
    chk("t3_ups", ups, 1);
    chk("t3_floor6", ifc.floor, 6);
    chk("t3_pending6", ifc.pending, 8'h02);
    door_len(dl);
    chk("t3_door6", dl, 4);
    chk("t3_rev_sel", ifc.sel, 1);
    chk("t3_rev_mode", ifc.mode, 0);
    travel(60, ups, downs, n);
    chk("t3_downs", downs, 5);
    chk("t3_ups_back", ups, 0);
    chk("t3_floor1", ifc.floor, 1);
    door_len(dl);
    chk("t3_door1", dl, 4);
    chk("t3_pending_end", ifc.pending, 0);

    // 4: calls {1,5} at floor 3 heading up; first reposition to get dir=1
    ifc.req = 8'h04; tick(); ifc.req = '0;
    travel(60, ups, downs, n);
    chk("t4_prep_ups", ups, 1);
    door_len(dl);
    ifc.floor = 8'd3;
    ifc.req = 8'h22; tick(); ifc.req = '0;
    travel(60, ups, downs, n);
    chk("t4_ups", ups, 2);
    chk("t4_downs_first", downs, 0);
    chk("t4_floor5", ifc.floor, 5);
    chk("t4_pending5", ifc.pending, 8'h02);
    door_len(dl);
    travel(60, ups, downs, n);
    chk("t4_downs", downs, 4);
    chk("t4_ups_second", ups, 0);
    chk("t4_floor1", ifc.floor, 1);
    door_len(dl);
    chk("t4_door1", dl, 4);
    chk("t4_busy_end", ifc.busy, 0);

    // 5: reset asserted in the middle of SETTLE
    ifc.req = 8'h81; tick(); ifc.req = '0;
    chk("t5_latched", ifc.pending, 8'h81);
    tick();
    chk("t5_step_sel", ifc.sel, 1);
    chk("t5_step_mode", ifc.mode, 0);
    tick();
    chk("t5_settle_sel", ifc.sel, 0);
    chk("t5_floor0", ifc.floor, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_pending", ifc.pending, 0);
    chk("t5_async_busy", ifc.busy, 0);
    chk("t5_async_mode", ifc.mode, 1);
    chk("t5_async_sel", ifc.sel, 0);
    chk("t5_async_door", ifc.door_open, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("t5_after_busy", ifc.busy, 0);
    chk("t5_after_pending", ifc.pending, 0);
    chk("t5_after_sel", ifc.sel, 0);

    // 6: top floor, only a call at the bottom
    ifc.floor = 8'd7;
    ifc.req = 8'h01; tick(); ifc.req = '0;
    travel(60, ups, downs, n);
    chk("t6_ups", ups, 0);
    chk("t6_downs", downs, 7);
    chk("t6_floor0", ifc.floor, 0);
    door_len(dl);
    chk("t6_door", dl, 4);
    chk("t6_pending", ifc.pending, 0);

    // 7: out-of-range floor drives the car down
    ifc.floor = 8'd10;
    ifc.req = 8'h80; tick(); ifc.req = '0;
    chk("t7_no_door", ifc.door_open, 0);
    travel(60, ups, downs, n);
    chk("t7_ups", ups, 0);
    chk("t7_downs", downs, 3);
    chk("t7_floor7", ifc.floor, 7);
    door_len(dl);
    chk("t7_door", dl, 4);
    chk("t7_busy_end", ifc.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
